pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the redirect address on trap or misaligned target.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  32  fetch address, always equal to pc.
REQ-007 SHALL have port imem_ack  input  1  memory has valid imem_rdata this cycle.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port instr_valid  output  1  one-cycle pulse that instr is new.
REQ-010 SHALL have port instr  output  32  registered current instruction.
REQ-011 SHALL have port pc  output  32  address of the current instruction.
REQ-012 SHALL have port exec_done  input  1  datapath finished instr; branch inputs valid.
REQ-013 SHALL have port branch_taken  input  1  branch/jump select from the datapath.
REQ-014 SHALL have port branch_target  input  32  pc plus offset from the branch adder.
REQ-015 SHALL have port trap  input  1  exception raised by the current instruction.
REQ-016 SHALL have port stall  input  1  hold before the next fetch.
REQ-017 SHALL have port halted  output  1  core stopped on EBREAK.
REQ-018 SHALL have port retire_count  output  32  count of retired instructions.

Function
REQ-019 SHALL implement states IDLE, FETCH, EXEC, HALT, encoded in a registered state variable.
REQ-020 IDLE: imem_req=0; stall=0 -> FETCH next cycle; stall=1 -> stay in IDLE.
REQ-021 FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack; pc SHALL not change in FETCH.
REQ-022 FETCH with imem_ack=1: instr<=imem_rdata, instr_valid=1 for exactly the next cycle, state -> EXEC.
REQ-023 imem_req SHALL be 0 in every state except FETCH; stall SHALL be ignored while in FETCH.
REQ-024 EXEC: wait for exec_done; exec_done in the same cycle as instr_valid SHALL be accepted; exec_done outside EXEC SHALL be ignored.
REQ-025 On exec_done, the next pc SHALL be selected by priority: trap -> TRAP_VECTOR; branch_taken with branch_target[1:0]!=0 -> TRAP_VECTOR; branch_taken -> branch_target; otherwise pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-026 On exec_done with instr==32'h0010_0073 (EBREAK) and trap=0, pc SHALL hold, halted<=1, state -> HALT; HALT SHALL be left only by reset.
REQ-027 On exec_done in all other cases, state SHALL go to IDLE if stall=1 or FETCH if stall=0.
REQ-028 retire_count SHALL increment by 1 (wrapping) on each exec_done without trap or misaligned redirect, including EBREAK.
REQ-029 instr_valid SHALL never be asserted in IDLE, FETCH or HALT.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force: state=IDLE, pc=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, halted=0, retire_count=0.
REQ-031 Reset during an outstanding fetch SHALL abandon it; an imem_ack arriving after reset release while in IDLE SHALL be ignored.
REQ-032 The first imem_req after rst_n rises SHALL occur no earlier than the second rising edge of clk.

Verification
REQ-033 Reset release, stall=0, ack 2 cycles after each req, exec_done 1 cycle after instr_valid -> imem_addr sequence 0,4,8; retire_count=3 after the third exec_done.
REQ-034 Branch: pc=0x10, branch_taken=1, branch_target=0x40 -> next imem_addr=0x40; branch_target=0x42 -> next imem_addr=0x100, and retire_count unchanged.
REQ-035 Trap with branch_taken=1 at pc=0x20 -> next imem_addr=0x100; stall=1 at exec_done -> imem_req=0 until stall falls, then fetch from 0x100.
REQ-036 imem_rdata=32'h0010_0073 with exec_done -> halted=1, imem_req stays 0 for 20 cycles, pc frozen; rst_n pulse -> pc=0, halted=0.
REQ-037 rst_n asserted mid-FETCH between edges -> imem_req drops in the same cycle; a late ack is ignored; refetch from RESET_VECTOR.
REQ-038 Wrap: pc=0xFFFF_FFFC, no branch -> next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/execute sequencer owning the program counter, instruction
//            register, redirect selection, EBREAK halt and retire counter.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap,
    input  logic        stall,
    output logic        halted,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] C_EBREAK = 32'h0010_0073;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_armed;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_halted;
    logic [31:0] r_retire_count;
    logic        w_load;
    logic        w_retire;
    logic        w_halt;
    logic        w_misaligned;

    assign w_misaligned = branch_taken && (branch_target[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_retire    = 1'b0;
        w_halt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_armed delays the first fetch by one edge after reset release
                if (r_armed && !stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_state_nxt = stall ? S_IDLE : S_FETCH;
                    if (trap) begin
                        w_pc_nxt = TRAP_VECTOR;
                    end else if (r_instr == C_EBREAK) begin
                        w_retire    = 1'b1;
                        w_halt      = 1'b1;
                        w_state_nxt = S_HALT;
                    end else if (w_misaligned) begin
                        w_pc_nxt = TRAP_VECTOR;
                    end else if (branch_taken) begin
                        w_pc_nxt = branch_target;
                        w_retire = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                        w_retire = 1'b1;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_armed        <= 1'b0;
            r_pc           <= RESET_VECTOR;
            r_instr        <= 32'h0000_0000;
            r_instr_valid  <= 1'b0;
            r_halted       <= 1'b0;
            r_retire_count <= 32'h0000_0000;
        end else begin
            r_state       <= w_state_nxt;
            r_armed       <= 1'b1;
            r_pc          <= w_pc_nxt;
            r_instr_valid <= w_load;
            if (w_load) begin
                r_instr <= imem_rdata;
            end
            if (w_halt) begin
                r_halted <= 1'b1;
            end
            if (w_retire) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    // Request is decoded from state so an asynchronous reset drops it at once
    assign imem_req     = (r_state == S_FETCH);
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign halted       = r_halted;
    assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic        stall;
    logic        halted;
    logic [31:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc            (pc),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap          (trap),
        .stall         (stall),
        .halted        (halted),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a fetch request; sampled on the falling edge
    task automatic wait_req(input string tag);
        int i;
        for (i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_req_seen"}, {31'd0, imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] data, input int delay);
        wait_req(tag);
        check({tag, "_addr"}, imem_addr, exp_addr);
        repeat (delay) @(negedge clk);
        check({tag, "_addr_held"}, imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_instr"}, instr, data);
        check({tag, "_req_drop"}, {31'd0, imem_req}, 32'd0);
    endtask

    task automatic do_exec(input int delay, input logic br, input logic [31:0] tgt,
                           input logic trp, input logic stl);
        repeat (delay) @(negedge clk);
        exec_done     = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        trap          = trp;
        stall         = stl;
        @(negedge clk);
        exec_done     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        trap          = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; trap = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req",    {31'd0, imem_req}, 32'd0);
        check("rst_pc",     pc, 32'h0);
        check("rst_instr",  instr, 32'h0);
        check("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retire", retire_count, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_edge_no_req", {31'd0, imem_req}, 32'd0);

        // Sequential fetches 0, 4, 8; third retires with a branch to 0x10
        do_fetch("f0", 32'h0, 32'h0000_0013, 2);
        do_exec(1, 1'b0, 32'h0, 1'b0, 1'b0);
        do_fetch("f4", 32'h4, 32'h0000_0013, 2);
        do_exec(1, 1'b0, 32'h0, 1'b0, 1'b0);
        do_fetch("f8", 32'h8, 32'h0000_0013, 2);
        check("f8_valid_pulse", {31'd0, instr_valid}, 32'd1);
        do_exec(1, 1'b1, 32'h10, 1'b0, 1'b0);
        check("retire3", retire_count, 32'd3);

        do_fetch("f10", 32'h10, 32'h0000_0063, 1);
        do_exec(1, 1'b1, 32'h40, 1'b0, 1'b0);
        check("retire4", retire_count, 32'd4);
        do_fetch("f40", 32'h40, 32'h0000_0063, 1);
        do_exec(1, 1'b1, 32'h42, 1'b0, 1'b0);
        check("misalign_no_retire", retire_count, 32'd4);
        do_fetch("f100a", 32'h100, 32'h0000_0063, 1);
        do_exec(1, 1'b1, 32'h20, 1'b0, 1'b0);

        // Trap beats branch; stall holds the sequencer in IDLE
        do_fetch("f20", 32'h20, 32'h0000_0063, 1);
        do_exec(1, 1'b1, 32'h40, 1'b1, 1'b1);
        check("trap_no_retire", retire_count, 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
            check("stall_pc", pc, 32'h100);
            @(negedge clk);
        end
        stall = 1'b0;
        do_fetch("f100b", 32'h100, 32'h0000_006F, 1);
        do_exec(1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        do_fetch("fwrap", 32'hFFFF_FFFC, 32'h0000_0013, 1);
        do_exec(1, 1'b0, 32'h0, 1'b0, 1'b0);
        do_fetch("f0b", 32'h0, 32'h0000_0013, 1);
        do_exec(1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("retire8", retire_count, 32'd8);

        // EBREAK with exec_done in the instr_valid cycle
        do_fetch("febrk", 32'h4, 32'h0010_0073, 1);
        do_exec(0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("halted", {31'd0, halted}, 32'd1);
        check("ebreak_retire", retire_count, 32'd9);
        exec_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("halt_no_req", {31'd0, imem_req}, 32'd0);
            check("halt_pc", pc, 32'h4);
            @(negedge clk);
        end
        exec_done = 1'b0;
        check("halt_ignore_done", retire_count, 32'd9);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);

        // Asynchronous reset pulse out of HALT
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc",     pc, 32'h0);
        check("arst_halted", {31'd0, halted}, 32'd0);
        check("arst_retire", retire_count, 32'd0);
        check("arst_instr",  instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-FETCH, then a late ack that must be ignored
        wait_req("mid");
        #2 rst_n = 1'b0;
        #1;
        check("mid_req_drop", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("late_ack_instr", instr, 32'h0);
        do_fetch("refetch", 32'h0, 32'h1234_5678, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
